// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pin bundle plus the local byte-side handshake of the SPI slave.
interface spi_slave_if;
   logic       sclk;
   logic       mosi;
   logic       cs;
   logic       miso;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       frame_err;
   modport slave (
      input  sclk, mosi, cs, tx_data,
      output miso, rx_data, rx_valid, busy, frame_err
   );
   modport master (
      output sclk, mosi, cs, tx_data,
      input  miso, rx_data, rx_valid, busy, frame_err
   );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI mode-0 slave, 8-bit MSB-first frames, back-to-back bytes within one cs period.
module spi_slave #(
   parameter int MIN_HALF = 4
) (
   input logic       clk,
   input logic       rst,
   spi_slave_if.slave bus
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t     state_q, state_d;
   logic [2:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic [7:0] half_cnt_q, half_cnt_d;
   logic       rx_valid_q, rx_valid_d;
   logic       frame_err_q, frame_err_d;
   logic       reload_q, reload_d;
   logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
   // events compare synchronizer stage 2 against the edge-detect stage 3
   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      rx_data_d   = rx_data_q;
      reload_d    = reload_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      half_cnt_d  = (sclk_rise || sclk_fall) ? 8'd0 : half_cnt_q + {7'd0, ~&half_cnt_q};
      if (state_q == IDLE) begin
         if (cs_fall) begin
            state_d    = ACTIVE;
            bit_cnt_d  = 3'd7;
            rx_shift_d = 8'd0;
            tx_shift_d = bus.tx_data;
            reload_d   = 1'b0;
         end
      end else if (cs_rise) begin
         // cs release wins over a coincident sclk edge, so a final fall does not shift
         state_d     = IDLE;
         frame_err_d = bit_cnt_q != 3'd7;
         reload_d    = 1'b0;
         tx_shift_d  = 8'd0;
         bit_cnt_d   = 3'd7;
      end else if (sclk_rise) begin
         rx_shift_d = {rx_shift_q[6:0], mosi_sync_q[1]};
         if (bit_cnt_q == 3'd0) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = 3'd7;
            reload_d   = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
         end
      end else if (sclk_fall) begin
         tx_shift_d = reload_q ? bus.tx_data : {tx_shift_q[6:0], 1'b0};
         reload_d   = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         sclk_sync_q <= 3'b000;
         mosi_sync_q <= 3'b000;
         cs_sync_q   <= 3'b111;
         bit_cnt_q   <= 3'd7;
         rx_shift_q  <= 8'd0;
         tx_shift_q  <= 8'd0;
         rx_data_q   <= 8'd0;
         half_cnt_q  <= 8'd0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         reload_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= {sclk_sync_q[1:0], bus.sclk};
         mosi_sync_q <= {mosi_sync_q[1:0], bus.mosi};
         cs_sync_q   <= {cs_sync_q[1:0], bus.cs};
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         rx_data_q   <= rx_data_d;
         half_cnt_q  <= half_cnt_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         reload_q    <= reload_d;
      end
   end
   assign bus.miso      = tx_shift_q[7];
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = state_q == ACTIVE;
   // the master must hold each sclk level for at least MIN_HALF clk cycles
   assert property (@(posedge clk) disable iff (!rst)
      (state_q == ACTIVE && (sclk_rise || sclk_fall)) |-> int'(half_cnt_q) >= MIN_HALF - 1);
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench driving the SPI slave as a mode-0 master.
module tb_spi_slave;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   rv_cnt = 0;
   int   fe_cnt = 0;
   int   both_cnt = 0;
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   spi_slave_if bus ();
   spi_slave #(.MIN_HALF(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (bus.rx_valid) rv_cnt++;
      if (bus.frame_err) fe_cnt++;
      if (bus.rx_valid && bus.frame_err) both_cnt++;
   end
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end
   task automatic xfer(input logic [7:0] mo0, input logic [7:0] mo1, input logic [7:0] to0,
                       input logic [7:0] to1, input int nbits, input int h, input bit rst_end);
      logic [7:0] got, exp_b;
      int w;
      got = 8'd0;
      bus.tx_data = to0;
      bus.cs = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         int b = i / 8;
         int k = 7 - (i % 8);
         logic [7:0] mb;
         mb = (b == 0) ? mo0 : mo1;
         if (k == 7) txq.push_back((b == 0) ? to0 : to1);
         bus.mosi = mb[k];
         repeat (h) @(negedge clk);
         got = {got[6:0], bus.miso};
         bus.sclk = 1'b1;
         if (k == 0) begin
            exp_b = txq.pop_front();
            n_checks++;
            if (got !== exp_b) begin
               n_fail++;
               $display("FAIL miso_byte: got %02h, required %02h", got, exp_b);
            end
            rxq.push_back(mb);
            w = 0;
            while (w < 8 && !bus.rx_valid) begin
               @(negedge clk);
               w++;
            end
            n_checks++;
            if (w !== 3) begin
               n_fail++;
               $display("FAIL rx_latency: got %0d, required 3", w);
            end
            exp_b = rxq.pop_front();
            n_checks++;
            if (bus.rx_valid !== 1'b1 || bus.rx_data !== exp_b) begin
               n_fail++;
               $display("FAIL rx_byte: got valid=%b data=%02h, required valid=1 data=%02h",
                        bus.rx_valid, bus.rx_data, exp_b);
            end
            if (b == 0 && nbits > 8) bus.tx_data = to1;
            repeat (h - w) @(negedge clk);
         end else begin
            repeat (h) @(negedge clk);
         end
         bus.sclk = 1'b0;
         if (i == nbits - 1 && !rst_end) bus.cs = 1'b1;
      end
      txq.delete();
      if (rst_end) begin
         #3 rst = 1'b0;
         #1;
         n_checks++;
         if ({bus.miso, bus.busy, bus.rx_valid, bus.frame_err, bus.rx_data} !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: got miso=%b busy=%b rv=%b fe=%b rx=%02h, required all 0",
                     bus.miso, bus.busy, bus.rx_valid, bus.frame_err, bus.rx_data);
         end
         bus.cs = 1'b1;
         repeat (3) @(negedge clk);
         rst = 1'b1;
      end
   endtask
   task automatic test_reset();
      bus.sclk = 1'b0;
      bus.mosi = 1'b0;
      bus.cs = 1'b1;
      bus.tx_data = 8'h00;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
      n_checks++;
      if (bus.miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b, required 0", bus.miso); end
      n_checks++;
      if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %02h, required 00", bus.rx_data); end
      n_checks++;
      if (bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pulses: got rv=%b fe=%b, required 0 0", bus.rx_valid, bus.frame_err);
      end
      rst = 1'b1;
      repeat (6) @(negedge clk);
   endtask
   task automatic test_single();
      int rv0 = rv_cnt, fe0 = fe_cnt;
      xfer(8'hA5, 8'h00, 8'h3C, 8'h00, 8, 4, 1'b0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold: got %b, required 1", bus.busy); end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b, required 0", bus.busy); end
      repeat (4) @(negedge clk);
      n_checks++;
      if (rv_cnt - rv0 !== 1 || fe_cnt - fe0 !== 0) begin
         n_fail++;
         $display("FAIL single_pulses: got rv=%0d fe=%0d, required 1 0", rv_cnt - rv0, fe_cnt - fe0);
      end
      n_checks++;
      if (bus.rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_rx_hold: got %02h, required a5", bus.rx_data); end
   endtask
   task automatic test_back_to_back();
      int rv0 = rv_cnt, fe0 = fe_cnt;
      xfer(8'h81, 8'h7E, 8'h11, 8'hEE, 16, 4, 1'b0);
      repeat (8) @(negedge clk);
      n_checks++;
      if (rv_cnt - rv0 !== 2 || fe_cnt - fe0 !== 0) begin
         n_fail++;
         $display("FAIL b2b_pulses: got rv=%0d fe=%0d, required 2 0", rv_cnt - rv0, fe_cnt - fe0);
      end
   endtask
   task automatic test_abort();
      int rv0 = rv_cnt, fe0 = fe_cnt;
      xfer(8'h5A, 8'h00, 8'hFF, 8'h00, 5, 4, 1'b0);
      repeat (8) @(negedge clk);
      n_checks++;
      if (fe_cnt - fe0 !== 1 || rv_cnt - rv0 !== 0) begin
         n_fail++;
         $display("FAIL abort_pulses: got fe=%0d rv=%0d, required 1 0", fe_cnt - fe0, rv_cnt - rv0);
      end
      n_checks++;
      if (bus.rx_data !== 8'h7E) begin n_fail++; $display("FAIL abort_rx_data: got %02h, required 7e", bus.rx_data); end
      n_checks++;
      if (bus.miso !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: got miso=%b busy=%b, required 0 0", bus.miso, bus.busy);
      end
   endtask
   task automatic test_noise();
      int rv0 = rv_cnt;
      bus.cs = 1'b1;
      bus.tx_data = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         bus.sclk = ~bus.sclk;
         bus.mosi = ~bus.mosi;
         repeat (4) @(negedge clk);
         n_checks++;
         if (bus.busy !== 1'b0 || bus.miso !== 1'b0) begin
            n_fail++;
            $display("FAIL noise_idle: got busy=%b miso=%b, required 0 0", bus.busy, bus.miso);
         end
      end
      n_checks++;
      if (rv_cnt - rv0 !== 0) begin n_fail++; $display("FAIL noise_rx_valid: got %0d, required 0", rv_cnt - rv0); end
   endtask
   task automatic test_reset_mid();
      int rv0 = rv_cnt, fe0 = fe_cnt;
      xfer(8'hF0, 8'h00, 8'hFF, 8'h00, 4, 4, 1'b1);
      repeat (8) @(negedge clk);
      n_checks++;
      if (rv_cnt - rv0 !== 0 || fe_cnt - fe0 !== 0) begin
         n_fail++;
         $display("FAIL reset_release_pulses: got rv=%0d fe=%0d, required 0 0", rv_cnt - rv0, fe_cnt - fe0);
      end
      xfer(8'hC3, 8'h00, 8'h96, 8'h00, 8, 4, 1'b0);
      repeat (6) @(negedge clk);
      n_checks++;
      if (bus.rx_data !== 8'hC3) begin n_fail++; $display("FAIL post_reset_rx: got %02h, required c3", bus.rx_data); end
   endtask
   task automatic test_min_timing();
      int rv0 = rv_cnt, fe0 = fe_cnt;
      for (int f = 0; f < 256; f++) begin
         xfer(8'($urandom_range(255)), 8'h00, 8'($urandom_range(255)), 8'h00, 8, 4, 1'b0);
         repeat (6) @(negedge clk);
      end
      n_checks++;
      if (rv_cnt - rv0 !== 256 || fe_cnt - fe0 !== 0) begin
         n_fail++;
         $display("FAIL min_timing_pulses: got rv=%0d fe=%0d, required 256 0", rv_cnt - rv0, fe_cnt - fe0);
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_abort();
      test_noise();
      test_reset_mid();
      test_min_timing();
      n_checks++;
      if (both_cnt !== 0 || rxq.size() !== 0) begin
         n_fail++;
         $display("FAIL final_state: got overlap=%0d pending=%0d, required 0 0", both_cnt, rxq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 slave, full-duplex, 8 bits per frame, MSB first. It is the peripheral-side counterpart of the team's SPI master and sits behind the external `sclk`/`mosi`/`cs` pins. It oversamples all SPI pins with the system clock, shifts in `mosi` on rising `sclk` edges, and drives `miso` with changes on falling `sclk` edges. It hands each received byte to local logic with a one-cycle strobe and takes the next transmit byte from local logic.

## Interface
Parameters:
- `MIN_HALF`, default 4: minimum `sclk` high or low time in `clk` cycles that the block guarantees to handle. Documentation and assertion only; not used in the datapath.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (low = reset).
- `sclk`  input  1  SPI clock from the master, asynchronous to `clk`, idle low.
- `mosi`  input  1  SPI data from the master.
- `cs`  input  1  chip select, active low, asynchronous.
- `tx_data`  input  8  next byte to transmit; sampled at frame start and at each byte boundary.
- `miso`  output  1  SPI data to the master.
- `rx_data`  output  8  last complete received byte; holds until the next byte completes.
- `rx_valid`  output  1  one-`clk` pulse when `rx_data` updates.
- `busy`  output  1  high while a frame is active (synchronized `cs` low).
- `frame_err`  output  1  one-`clk` pulse when `cs` rises mid-byte.

## Operation
- **Input synchronization.** `sclk`, `mosi` and `cs` each pass through a 2-flop synchronizer, then a third edge-detect register.
- **Edge events.** An event fires on the `clk` edge where stage 2 differs from stage 3, and its action is registered on that edge.
  - `cs_fall`, `cs_rise`, `sclk_rise`, `sclk_fall` are defined this way.
  - Data is sampled from synchronized `mosi` stage 2.
- **States.**
  - IDLE: `busy`=0, `miso`=0, `bit_cnt`=7, `tx_shift`=0.
  - ACTIVE: entered on `cs_fall`; left on `cs_rise` or reset.
- **IDLE → ACTIVE on `cs_fall`.**
  - `busy`<=1, `bit_cnt`<=7, `rx_shift`<=0.
  - `tx_shift`<=`tx_data`, so `miso` = `tx_data[7]` before the first `sclk` rise.
- **ACTIVE, `sclk_rise`.**
  - `rx_shift`<={`rx_shift[6:0]`, `mosi`}.
  - If `bit_cnt`==0: `rx_data`<={`rx_shift[6:0]`, `mosi`}, `rx_valid`<=1, `bit_cnt`<=7, `reload`<=1.
  - Otherwise: `bit_cnt`<=`bit_cnt`-1.
- **ACTIVE, `sclk_fall`.**
  - If `reload`: `tx_shift`<=`tx_data`, `reload`<=0. This is a back-to-back byte within one `cs` low period.
  - Otherwise: `tx_shift`<={`tx_shift[6:0]`, 0}.
- **`miso`** = `tx_shift[7]`, driven from a register; 0 whenever IDLE.
- **ACTIVE → IDLE on `cs_rise`.**
  - If `bit_cnt`!=7 (partial byte): `frame_err`<=1 and the partial byte is discarded; `rx_data` is unchanged and there is no `rx_valid`.
  - Clear `reload` and `tx_shift`, and set `bit_cnt`<=7.
- **Simultaneous events.**
  - `cs_rise` has priority over any `sclk` event on the same cycle. This covers the master releasing `cs` together with the final `sclk` fall: no shift, no error.
  - `sclk` events while IDLE are ignored.
- **Reset (any time, including mid-frame).**
  - All outputs go to 0 immediately, and synchronizers go to their idle values (`cs` stages = 1, others = 0).
  - `rx_data`=0, `busy`=0.
  - No `rx_valid` or `frame_err` is generated on reset release.

## Timing
- Pin-to-action latency is 3 `clk` rising edges.
  - `miso` valid ≤3 `clk` after `cs` falls.
  - `rx_valid` pulses 3 `clk` after the pin-level 8th `sclk` rise.
  - `miso` updates 3 `clk` after each `sclk` fall.
- Requirements on the master:
  - `sclk` high and low times ≥ `MIN_HALF` (4) `clk` cycles.
  - `cs` fall to first `sclk` rise ≥ 4 `clk`.
- The team master (50 MHz / 1 MHz, 25-cycle half period) satisfies these with margin.
- `rx_valid` and `frame_err` are exactly 1 cycle wide; at most one of them is asserted per cycle.
- `tx_data` must be stable from `cs` fall +3 `clk`, and from the `rx_valid` cycle until the next `sclk_fall` is acted on.

## Test plan
- **Single byte.** Master sends 0xA5 with `tx_data`=0x3C → `rx_valid` pulses once, `rx_data`=0xA5, master sees `miso` bits 0,0,1,1,1,1,0,0, `busy` falls 3 `clk` after `cs` rises, `frame_err`=0.
- **Back-to-back.** Two bytes 0x81, 0x7E in one `cs` low period; `tx_data` changed from 0x11 to 0xEE after the first `rx_valid` → two `rx_valid` pulses with `rx_data` 0x81 then 0x7E; `miso` carries 0x11 then 0xEE.
- **Abort.** `cs` rises after 5 `sclk` rises → `frame_err` pulses once, no `rx_valid`, `rx_data` keeps its prior value, `miso`=0.
- **Noise while idle.** `sclk` toggled 10 times with `cs` high → no `rx_valid`, `busy`=0, `miso`=0 throughout.
- **Reset mid-frame.** `rst` low after 4 bits → all outputs 0 asynchronously. After `rst` high and a fresh frame 0xC3 → `rx_data`=0xC3.
- **Minimum timing.** 4-cycle `sclk` half-periods, randomized bytes over 256 frames → every `rx_data` matches the byte sent and every `miso` byte matches `tx_data`.
